uart_tx_port: RTL

- Memory-mapped serial output port for the monocycle CPU.
- The CPU writes 8-bit bytes into a small transmit FIFO, using the same style of single-cycle write strobe as the register-file write port.
- The block serialises each byte as an 8N1 UART frame on `tx`, LSB first.
- It is the transmitting end paired with the board's UART receive path; it sits on the CPU data bus next to the register file.

---
 rtl/uart_tx_port.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_port.sv
// uart_tx_port: CPU write strobe enqueues into a 2**FIFO_AW FIFO drained by an 8N1 serialiser on tx (8E1 when UART_TX_PARITY_EN).
// Write at edge N into an idle block -> start bit after edge N+1; writes while full are dropped and raise sticky ovf.
module uart_tx_port #(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 434,
    parameter int FIFO_AW = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [WIDTH-1:0] wd,
    input  logic             ovf_clr,
    output logic             full,
    output logic             empty,
    output logic             busy,
    output logic             ovf,
    output logic             tx
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int BCW   = $clog2(CLK_DIV);
    localparam int BIW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [BCW-1:0]     BC_RELOAD = BCW'(CLK_DIV - 1);
    localparam logic [BIW-1:0]     BI_LAST   = BIW'(WIDTH - 1);
    localparam logic [FIFO_AW:0]   CNT_FULL  = (FIFO_AW + 1)'(DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    state_t             state_q, state_d;
    logic [BCW-1:0]     bc_q, bc_d;
    logic [BIW-1:0]     bi_q, bi_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic               tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic               par_q, par_d;
`endif
    logic               push;
    logic               pop;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    assign busy  = (state_q != S_IDLE) || !empty;
    assign ovf   = ovf_q;
    assign tx    = tx_q;

    // full is the pre-edge view, so a pop on the same edge never rescues a write
    assign push = we && !full;

    always_comb begin
        state_d = state_q;
        bc_d    = bc_q;
        bi_d    = bi_q;
        sh_d    = sh_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    sh_d    = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
                    par_d   = ^mem_q[rd_ptr_q];
`endif
                    bc_d    = BC_RELOAD;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bc_q == '0) begin
                    bc_d    = BC_RELOAD;
                    bi_d    = '0;
                    state_d = S_DATA;
                end else begin
                    bc_d = bc_q - 1'b1;
                end
            end
            S_DATA: begin
                if (bc_q == '0) begin
                    sh_d = sh_q >> 1;
                    bc_d = BC_RELOAD;
                    if (bi_q == BI_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bi_d = bi_q + 1'b1;
                    end
                end else begin
                    bc_d = bc_q - 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bc_q == '0) begin
                    bc_d    = BC_RELOAD;
                    state_d = S_STOP;
                end else begin
                    bc_d = bc_q - 1'b1;
                end
            end
`endif
            S_STOP: begin
                // Returning to IDLE costs one extra high cycle before the next pop
                if (bc_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    bc_d = bc_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // tx is registered, so it is derived from where the FSM is heading
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = sh_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = par_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // a fresh overflow on the same edge as a clear keeps the flag set
        ovf_d = (ovf_q && !ovf_clr) || (we && full);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            state_q  <= S_IDLE;
            bc_q     <= '0;
            bi_q     <= '0;
            sh_q     <= '0;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            bc_q     <= bc_d;
            bi_q     <= bi_d;
            sh_q     <= sh_d;
            tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

endmodule
